// File: rtl/gshare_branch_predictor_pkg.sv
// FetchUnitTypes: shared gshare types, PHT counter encoding and saturating counter step.
package FetchUnitTypes;
    localparam int PHT_INDEX_WIDTH = 8;
    typedef logic [PHT_INDEX_WIDTH-1:0] PHTIndex;
    typedef logic [PHT_INDEX_WIDTH-1:0] GlobalBranchHistory;
    typedef enum logic [1:0] {STRONG_NT, WEAK_NT, WEAK_T, STRONG_T} PHTCounter;

    function automatic PHTCounter sat_count(input PHTCounter c, input logic taken);
        return taken ? (c == STRONG_T ? STRONG_T : PHTCounter'(c + 2'd1))
                     : (c == STRONG_NT ? STRONG_NT : PHTCounter'(c - 2'd1));
    endfunction
endpackage

// File: rtl/gshare_branch_predictor_if.sv
// BranchPredictorIF: prediction payload handed from the predictor to fetch.
interface BranchPredictorIF;
    import FetchUnitTypes::*;
    PHTIndex            phtIndex;
    logic               isBranchTakenPredicted;
    GlobalBranchHistory globalBranchHistory;
    modport BranchPredictor(output phtIndex, isBranchTakenPredicted, globalBranchHistory);
    modport Fetch(input phtIndex, isBranchTakenPredicted, globalBranchHistory);
endinterface

// File: rtl/gshare_branch_predictor_pht.sv
// pattern_history_table: 2-bit counter array with one read port and one saturating update port.
module pattern_history_table
    import FetchUnitTypes::*;
(
    input  logic    clk,
    input  logic    rst,
    input  PHTIndex rd_idx,
    output logic    rd_taken,
    input  logic    upd_valid,
    input  PHTIndex upd_idx,
    input  logic    upd_taken
);
    PHTCounter pht_q [2**PHT_INDEX_WIDTH];
    PHTCounter pht_d [2**PHT_INDEX_WIDTH];

    always_comb begin
        pht_d = pht_q;
        if (upd_valid) pht_d[upd_idx] = sat_count(pht_q[upd_idx], upd_taken);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2**PHT_INDEX_WIDTH; i++) pht_q[i] <= WEAK_NT;
        end else begin
            pht_q <= pht_d;
        end
    end

    // Read sees the pre-update array, so a same-cycle update to this index is not visible yet.
    assign rd_taken = pht_q[rd_idx][1];
endmodule

// File: rtl/gshare_branch_predictor.sv
// gshare_branch_predictor: PC^GHR indexed PHT, 1-cycle prediction latency.
// BRANCH_PREDICTOR_SPECULATIVE_GHR_EN: shift GHR at prediction time and repair it on mispredict.
module gshare_branch_predictor
    import FetchUnitTypes::*;
#(
    parameter int PC_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fetchValid,
    input  logic                 fetchStall,
    input  logic [PC_WIDTH-1:0]  fetchPC,
    input  logic                 fetchIsBranch,
    BranchPredictorIF.BranchPredictor bp,
    output logic                 predictionValid,
    input  logic                 updateValid,
    input  PHTIndex              updatePHTIndex,
    input  GlobalBranchHistory   updateGlobalHistory,
    input  logic                 updateIsBranchTaken,
    input  logic                 updateIsMispredicted
);
    GlobalBranchHistory ghr_q, ghr_d, hist_q, hist_d;
    PHTIndex lookup_idx, pht_index_q, pht_index_d;
    logic accept, rd_taken, valid_q, valid_d, pred_q, pred_d;
    logic unused_bits;

    assign accept     = fetchValid & !fetchStall;
    assign lookup_idx = fetchPC[PHT_INDEX_WIDTH+1:2] ^ ghr_q;

    pattern_history_table u_pht (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (lookup_idx),
        .rd_taken  (rd_taken),
        .upd_valid (updateValid),
        .upd_idx   (updatePHTIndex),
        .upd_taken (updateIsBranchTaken)
    );

    always_comb begin
        valid_d     = fetchStall ? valid_q : accept;
        pht_index_d = accept ? lookup_idx : pht_index_q;
        pred_d      = accept ? rd_taken : pred_q;
        hist_d      = accept ? ghr_q : hist_q;
`ifdef BRANCH_PREDICTOR_SPECULATIVE_GHR_EN
        // Mispredict recovery overrides any speculative shift in the same cycle.
        ghr_d = (updateValid & updateIsMispredicted)
                    ? {updateGlobalHistory[PHT_INDEX_WIDTH-2:0], updateIsBranchTaken}
                    : (accept & fetchIsBranch) ? {ghr_q[PHT_INDEX_WIDTH-2:0], rd_taken} : ghr_q;
`else
        ghr_d = updateValid ? {ghr_q[PHT_INDEX_WIDTH-2:0], updateIsBranchTaken} : ghr_q;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ghr_q       <= '0;
            hist_q      <= '0;
            pht_index_q <= '0;
            valid_q     <= 1'b0;
            pred_q      <= 1'b0;
        end else begin
            ghr_q       <= ghr_d;
            hist_q      <= hist_d;
            pht_index_q <= pht_index_d;
            valid_q     <= valid_d;
            pred_q      <= pred_d;
        end
    end

    assign predictionValid           = valid_q;
    assign bp.phtIndex               = pht_index_q;
    assign bp.isBranchTakenPredicted = pred_q;
    assign bp.globalBranchHistory    = hist_q;

`ifdef BRANCH_PREDICTOR_SPECULATIVE_GHR_EN
    assign unused_bits = ^{fetchPC[PC_WIDTH-1:PHT_INDEX_WIDTH+2], fetchPC[1:0],
                           updateGlobalHistory[PHT_INDEX_WIDTH-1]};
`else
    assign unused_bits = ^{fetchPC[PC_WIDTH-1:PHT_INDEX_WIDTH+2], fetchPC[1:0], fetchIsBranch,
                           updateGlobalHistory, updateIsMispredicted};
`endif
endmodule

// File: tb/tb_gshare_branch_predictor.sv
// tb_gshare_branch_predictor: table-driven vectors with a scoreboard queue, plus a mid-run async reset.
module tb_gshare_branch_predictor;
    typedef struct {
        logic        fv, st, br;
        logic [31:0] pc;
        logic        uv;
        logic [7:0]  ui;
        logic        ut, um;
        logic [7:0]  ug;
        logic        ev, chk;
        logic [7:0]  ei;
        logic        ep;
        logic [7:0]  eh;
    } vec_t;

    logic clk = 1'b0, rst = 1'b0;
    logic fetchValid = 0, fetchStall = 0, fetchIsBranch = 0, predictionValid;
    logic [31:0] fetchPC = '0;
    logic updateValid = 0, updateIsBranchTaken = 0, updateIsMispredicted = 0;
    logic [7:0] updatePHTIndex = '0, updateGlobalHistory = '0;
    int total = 0, bad = 0;
    vec_t tab1[$], tab2[$], sb[$];

    BranchPredictorIF bp_if();

    gshare_branch_predictor #(.PC_WIDTH(32)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .fetchValid           (fetchValid),
        .fetchStall           (fetchStall),
        .fetchPC              (fetchPC),
        .fetchIsBranch        (fetchIsBranch),
        .bp                   (bp_if),
        .predictionValid      (predictionValid),
        .updateValid          (updateValid),
        .updatePHTIndex       (updatePHTIndex),
        .updateGlobalHistory  (updateGlobalHistory),
        .updateIsBranchTaken  (updateIsBranchTaken),
        .updateIsMispredicted (updateIsMispredicted)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic fv, st, br, input logic [31:0] pc, input logic uv,
                                input logic [7:0] ui, input logic ut, um, input logic [7:0] ug,
                                input logic ev, chk, input logic [7:0] ei, input logic ep,
                                input logic [7:0] eh);
        vec_t v;
        v.fv = fv; v.st = st; v.br = br; v.pc = pc; v.uv = uv; v.ui = ui; v.ut = ut; v.um = um;
        v.ug = ug; v.ev = ev; v.chk = chk; v.ei = ei; v.ep = ep; v.eh = eh;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic apply(input string tag, input vec_t v);
        vec_t e;
        fetchValid = v.fv; fetchStall = v.st; fetchIsBranch = v.br; fetchPC = v.pc;
        updateValid = v.uv; updatePHTIndex = v.ui; updateIsBranchTaken = v.ut;
        updateIsMispredicted = v.um; updateGlobalHistory = v.ug;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({tag, " valid"}, 32'(predictionValid), 32'(e.ev));
        if (e.chk) begin
            check({tag, " idx"}, 32'(bp_if.phtIndex), 32'(e.ei));
            check({tag, " pred"}, 32'(bp_if.isBranchTakenPredicted), 32'(e.ep));
            check({tag, " hist"}, 32'(bp_if.globalBranchHistory), 32'(e.eh));
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " valid"}, 32'(predictionValid), 32'd0);
        check({tag, " idx"}, 32'(bp_if.phtIndex), 32'd0);
        check({tag, " pred"}, 32'(bp_if.isBranchTakenPredicted), 32'd0);
        check({tag, " hist"}, 32'(bp_if.globalBranchHistory), 32'd0);
    endtask

    initial begin
`ifdef BRANCH_PREDICTOR_SPECULATIVE_GHR_EN
        // Train idx 0x01, then three taken speculative shifts, mispredict repair, repair-vs-shift race.
        tab1.push_back(mk(0,0,0,32'h0,  1,8'h01,1,0,8'h00, 0,0,8'h00,0,8'h00));
        tab1.push_back(mk(1,0,1,32'h04, 0,8'h00,0,0,8'h00, 1,1,8'h01,1,8'h00));
        tab1.push_back(mk(1,0,1,32'h00, 0,8'h00,0,0,8'h00, 1,1,8'h01,1,8'h01));
        tab1.push_back(mk(1,0,1,32'h08, 0,8'h00,0,0,8'h00, 1,1,8'h01,1,8'h03));
        tab1.push_back(mk(0,0,0,32'h0,  1,8'h40,0,1,8'h01, 0,1,8'h01,1,8'h03));
        tab1.push_back(mk(1,0,0,32'h00, 0,8'h00,0,0,8'h00, 1,1,8'h02,0,8'h02));
        tab1.push_back(mk(1,0,1,32'h0C, 1,8'h40,1,1,8'h10, 1,1,8'h01,1,8'h02));
        tab1.push_back(mk(1,0,0,32'h00, 0,8'h00,0,0,8'h00, 1,1,8'h21,0,8'h21));
        tab1.push_back(mk(0,0,0,32'h0,  1,8'h21,1,0,8'h00, 0,1,8'h21,0,8'h21));
        tab1.push_back(mk(1,0,0,32'h00, 0,8'h00,0,0,8'h00, 1,1,8'h21,1,8'h21));
        tab1.push_back(mk(1,1,1,32'h3FC,0,8'h00,0,0,8'h00, 1,1,8'h21,1,8'h21));
        tab1.push_back(mk(1,0,0,32'h00, 0,8'h00,0,0,8'h00, 1,1,8'h21,1,8'h21));
        tab2.push_back(mk(1,0,1,32'h48, 0,8'h00,0,0,8'h00, 1,1,8'h12,0,8'h00));
`else
        // GHR built from update outcomes only; mispredict fields and fetchIsBranch must be ignored.
        tab1.push_back(mk(0,0,0,32'h0,  1,8'hF0,1,1,8'hAA, 0,0,8'h00,0,8'h00));
        tab1.push_back(mk(0,0,0,32'h0,  1,8'hF0,0,1,8'hAA, 0,0,8'h00,0,8'h00));
        tab1.push_back(mk(0,0,0,32'h0,  1,8'hF0,1,0,8'h00, 0,0,8'h00,0,8'h00));
        tab1.push_back(mk(1,0,1,32'hFFFF_F040, 0,8'h00,0,0,8'h00, 1,1,8'h15,0,8'h05));
        tab1.push_back(mk(1,0,1,32'h43, 1,8'h15,1,0,8'h00, 1,1,8'h15,0,8'h05));
        tab1.push_back(mk(1,0,1,32'h78, 0,8'h00,0,0,8'h00, 1,1,8'h15,1,8'h0B));
        for (int i = 0; i < 3; i++)
            tab1.push_back(mk(1,1,1,32'h123C, 0,8'h00,0,0,8'h00, 1,1,8'h15,1,8'h0B));
        tab1.push_back(mk(0,0,0,32'h0,  0,8'h00,0,0,8'h00, 0,1,8'h15,1,8'h0B));
        for (int i = 0; i < 4; i++)
            tab1.push_back(mk(0,0,0,32'h0, 1,8'h12,1,0,8'h00, 0,0,8'h00,0,8'h00));
        tab1.push_back(mk(1,0,1,32'h2B4,0,8'h00,0,0,8'h00, 1,1,8'h12,1,8'hBF));
        tab1.push_back(mk(0,0,0,32'h0,  1,8'h12,0,0,8'h00, 0,0,8'h00,0,8'h00));
        tab1.push_back(mk(1,0,1,32'h1B0,0,8'h00,0,0,8'h00, 1,1,8'h12,1,8'h7E));
        tab1.push_back(mk(0,0,0,32'h0,  1,8'h12,1,0,8'h00, 0,0,8'h00,0,8'h00));
        tab1.push_back(mk(1,0,1,32'h3BC,0,8'h00,0,0,8'h00, 1,1,8'h12,1,8'hFD));
        // After reset: counter back at 01, plus saturation at 00.
        tab2.push_back(mk(1,0,1,32'h48, 0,8'h00,0,0,8'h00, 1,1,8'h12,0,8'h00));
        tab2.push_back(mk(0,0,0,32'h0,  1,8'h12,1,0,8'h00, 0,0,8'h00,0,8'h00));
        tab2.push_back(mk(1,0,0,32'h4C, 0,8'h00,0,0,8'h00, 1,1,8'h12,1,8'h01));
        tab2.push_back(mk(0,0,0,32'h0,  1,8'h30,0,0,8'h00, 0,0,8'h00,0,8'h00));
        tab2.push_back(mk(0,0,0,32'h0,  1,8'h30,0,0,8'h00, 0,0,8'h00,0,8'h00));
        tab2.push_back(mk(0,0,0,32'h0,  1,8'h30,1,0,8'h00, 0,0,8'h00,0,8'h00));
        tab2.push_back(mk(1,0,0,32'hE4, 0,8'h00,0,0,8'h00, 1,1,8'h30,0,8'h09));
`endif
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b1;
        foreach (tab1[i]) apply($sformatf("t1[%0d]", i), tab1[i]);
        check("pre-rst valid", 32'(predictionValid), 32'd1);
        check("pre-rst pred", 32'(bp_if.isBranchTakenPredicted), 32'd1);
        fetchValid = 1'b0; updateValid = 1'b0;
        #2 rst = 1'b0;
        #1 check_zero("async rst");
        @(posedge clk);
        #1 rst = 1'b1;
        foreach (tab2[i]) apply($sformatf("t2[%0d]", i), tab2[i]);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
